bicubic_row_phase: RTL and testbench
====================================

# bicubic_row_phase

Vertical phase generator for the bicubic scaler. Per output line it computes the source-row base index, the Q8 fractional phase and the four clamped tap row indices. It also produces the four tap distances (Q8) that feed the per-tap weight stages. The y1 weight stage, for example, takes `dist1` as its `yBlend` input. It sits between the line-buffer controller, which issues `line_req` and consumes the row indices, and the weight stages.

## Interface
- `FRAC`, 8: fractional bits of `step` and of the phase.
- `HW`, 12: integer bits for heights and row indices.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse that loads the configuration and starts a frame.
- `step` in 20: Q12.8 unsigned step, equal to src_h·256/dst_h. Sampled on `frame_start`.
- `src_height` in 12: source rows, at least 1. Sampled on `frame_start`.
- `dst_height` in 12: output rows. Sampled on `frame_start`.
- `line_req` in 1: pulse that advances to the next output line.
- `row_valid` out 1: one-cycle pulse; all row and distance outputs are valid and held until the next update.
- `busy` out 1: high from frame start until the frame completes.
- `frame_done` out 1: one-cycle pulse after the last line is released.
- `dst_row` out 12: current output line index.
- `row_m1`, `row_0`, `row_p1`, `row_p2` out 12 each: clamped source rows for taps 0 to 3.
- `y_frac` out 8: fractional phase, 0 to 255.
- `dist0` out 10: 256+frac.
- `dist1` out 9: frac.
- `dist2` out 9: 256−frac.
- `dist3` out 10: 512−frac.

## Operation
- Accumulator `acc`: signed, 22 bits, Q13.8. Centre alignment: on `frame_start`, `acc` = (step>>1) − 128 and `dst_row` = 0.
- Base and fraction from `acc`:
  - If `acc` < 0: base = 0, frac = 0.
  - Otherwise, if acc[21:8] ≥ src_height−1: base = src_height−1, frac = 0.
  - Otherwise: base = acc[19:8], frac = acc[7:0].
- Taps:
  - `row_m1` = max(base−1, 0).
  - `row_0` = base.
  - `row_p1` = min(base+1, src_height−1).
  - `row_p2` = min(base+2, src_height−1).
- Distances are computed from the clamped frac. `dist2` can reach 256, which is why it is 9 bits.
- State machine:
  - IDLE: on `frame_start` with `dst_height` ≠ 0, latch the configuration, initialise `acc` and go to CALC. If `dst_height` = 0, ignore the pulse and stay in IDLE.
  - CALC: register all outputs, pulse `row_valid`, go to WAIT.
  - WAIT, on `line_req`, not the last line: `acc` += step, `dst_row`++, go to CALC.
  - WAIT, on `line_req`, `dst_row` = dst_height−1: pulse `frame_done`, go to IDLE.
- `line_req` is ignored in IDLE and CALC; it is not queued.
- `frame_start` in any state restarts the frame immediately and has priority over a simultaneous `line_req`.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, `acc` 0.
- Reset asserted mid-frame aborts the frame immediately. No `frame_done` is produced.
- `frame_start` sampled at edge E0 gives state CALC after E0. Outputs update at E1, and `row_valid` is high for the one cycle following E1, so latency is 2 edges.
- `line_req` sampled at edge Ek in WAIT gives `row_valid` in the cycle after Ek+1.
- `frame_done` is high for the cycle following the edge that samples the final `line_req`. `busy` falls at the same edge.
- Row and distance outputs hold their values until the next CALC, including through IDLE after the frame ends.
- Back-to-back `line_req` pulses on consecutive cycles: the second pulse lands in CALC and is dropped.

## Test plan
- Upscale, src 1080 / dst 2160, step = 128:
  - First line: `acc` = −64, so rows 0, 0, 1, 2, frac 0, distances 256, 0, 256, 512.
  - Second line: `acc` = 64, so rows 0, 0, 1, 2, frac 64, distances 320, 64, 192, 448.
- Upscale bottom edge, same configuration, line 2159: `acc` = 276288, so base is clamped to 1079, frac 0, rows 1078, 1079, 1079, 1079. The next `line_req` produces `frame_done`, and `busy` goes to 0.
- Downscale, src 2160 / dst 1080, step = 512:
  - Line 0: `acc` = 128, so base 0, frac 128, rows 0, 0, 1, 2.
  - Line 1: `acc` = 640, so base 2, frac 128, rows 1, 2, 3, 4.
- Latency: `frame_start` at E0 gives `row_valid` after E1. `line_req` at Ek gives `row_valid` after Ek+1. A `line_req` during CALC is ignored, and `dst_row` does not change.
- Restart and degenerate config:
  - `frame_start` while in WAIT at `dst_row` 37 resets `dst_row` to 0 and recomputes the first line.
  - `dst_height` = 0 leaves `busy` at 0.
  - `src_height` = 1 gives all four taps = 0.
- Async reset asserted while in WAIT: all outputs go to 0 immediately, no `frame_done` pulse, and a fresh `frame_start` after reset operates normally.

Source files
------------

// File: rtl/bicubic_row_phase.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_row_phase
// Purpose  : Vertical phase generator for the bicubic scaler: source row base,
//            Q8 phase, four clamped tap rows and four Q8 tap distances.
// Revision : 1.0
// ============================================================================
module bicubic_row_phase #(
    parameter int FRAC = 8,
    parameter int HW   = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [HW+FRAC-1:0]  step,
    input  logic [HW-1:0]       src_height,
    input  logic [HW-1:0]       dst_height,
    input  logic                line_req,
    output logic                row_valid,
    output logic                busy,
    output logic                frame_done,
    output logic [HW-1:0]       dst_row,
    output logic [HW-1:0]       row_m1,
    output logic [HW-1:0]       row_0,
    output logic [HW-1:0]       row_p1,
    output logic [HW-1:0]       row_p2,
    output logic [FRAC-1:0]     y_frac,
    output logic [FRAC+1:0]     dist0,
    output logic [FRAC:0]       dist1,
    output logic [FRAC:0]       dist2,
    output logic [FRAC+1:0]     dist3
);

    localparam int c_ACC_W = HW + FRAC + 2;
    localparam logic [FRAC+1:0]       c_ONE  = {2'b01, {FRAC{1'b0}}};
    localparam logic [FRAC+1:0]       c_TWO  = {2'b10, {FRAC{1'b0}}};
    localparam logic [c_ACC_W-1:0]    c_HALF = {{(c_ACC_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [c_ACC_W-1:0] r_acc;
    logic [HW+FRAC-1:0]        r_step;
    logic [HW-1:0]             r_src_h;
    logic [HW-1:0]             r_dst_h;

    logic                      w_start;
    logic                      w_advance;
    logic                      w_done;
    logic [HW-1:0]             w_last_row;
    logic [c_ACC_W-FRAC-1:0]   w_int;
    logic [HW-1:0]             w_base;
    logic [FRAC-1:0]           w_frac;
    logic [HW:0]               w_b1;
    logic [HW:0]               w_b2;
    logic [HW-1:0]             w_m1;
    logic [HW-1:0]             w_p1;
    logic [HW-1:0]             w_p2;

    // A zero-height request is not a frame; it is dropped in every state.
    assign w_start = frame_start && (dst_height != '0);
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_done      = 1'b0;
        if (w_start) begin
            w_state_nxt = S_CALC;
        end else begin
            case (r_state)
                S_CALC: w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (line_req) begin
                        if (dst_row == r_dst_h - 1'b1) begin
                            w_state_nxt = S_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_state_nxt = S_CALC;
                            w_advance   = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Base row and phase, clamped at the top (negative acc) and bottom edges.
    assign w_last_row = (r_src_h == '0) ? '0 : r_src_h - 1'b1;
    assign w_int      = r_acc[c_ACC_W-1:FRAC];

    always_comb begin
        w_base = '0;
        w_frac = '0;
        if (r_acc[c_ACC_W-1]) begin
            w_base = '0;
            w_frac = '0;
        end else if (w_int >= {2'b00, w_last_row}) begin
            w_base = w_last_row;
            w_frac = '0;
        end else begin
            w_base = r_acc[HW+FRAC-1:FRAC];
            w_frac = r_acc[FRAC-1:0];
        end
    end

    assign w_b1 = {1'b0, w_base} + 1'b1;
    assign w_b2 = {1'b0, w_base} + 2'd2;
    assign w_m1 = (w_base == '0) ? '0 : w_base - 1'b1;
    assign w_p1 = (w_b1 > {1'b0, w_last_row}) ? w_last_row : w_b1[HW-1:0];
    assign w_p2 = (w_b2 > {1'b0, w_last_row}) ? w_last_row : w_b2[HW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_step     <= '0;
            r_src_h    <= '0;
            r_dst_h    <= '0;
            dst_row    <= '0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
            row_m1     <= '0;
            row_0      <= '0;
            row_p1     <= '0;
            row_p2     <= '0;
            y_frac     <= '0;
            dist0      <= '0;
            dist1      <= '0;
            dist2      <= '0;
            dist3      <= '0;
        end else begin
            row_valid  <= 1'b0;
            frame_done <= w_done;
            if (w_start) begin
                r_step  <= step;
                r_src_h <= src_height;
                r_dst_h <= dst_height;
                // Centre alignment: half a step minus half a source pixel.
                r_acc   <= $signed({{(c_ACC_W-HW-FRAC+1){1'b0}}, step[HW+FRAC-1:1]}) - $signed(c_HALF);
                dst_row <= '0;
            end else if (w_advance) begin
                r_acc   <= r_acc + $signed({2'b00, r_step});
                dst_row <= dst_row + 1'b1;
            end
            if (r_state == S_CALC && !w_start) begin
                row_valid <= 1'b1;
                row_m1    <= w_m1;
                row_0     <= w_base;
                row_p1    <= w_p1;
                row_p2    <= w_p2;
                y_frac    <= w_frac;
                dist0     <= c_ONE + {2'b00, w_frac};
                dist1     <= {1'b0, w_frac};
                dist2     <= c_ONE[FRAC:0] - {1'b0, w_frac};
                dist3     <= c_TWO - {2'b00, w_frac};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bicubic_row_phase.sv
`default_nettype none
// ============================================================================
// Module   : tb_bicubic_row_phase
// Purpose  : Scoreboard bench for bicubic_row_phase with directed line vectors.
// Revision : 1.0
// ============================================================================
module tb_bicubic_row_phase;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [19:0] step = '0;
    logic [11:0] src_height = '0;
    logic [11:0] dst_height = '0;
    logic        line_req = 1'b0;
    logic        row_valid, busy, frame_done;
    logic [11:0] dst_row, row_m1, row_0, row_p1, row_p2;
    logic [7:0]  y_frac;
    logic [9:0]  dist0, dist3;
    logic [8:0]  dist1, dist2;

    bicubic_row_phase #(.FRAC(8), .HW(12)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .step(step),
        .src_height(src_height), .dst_height(dst_height), .line_req(line_req),
        .row_valid(row_valid), .busy(busy), .frame_done(frame_done),
        .dst_row(dst_row), .row_m1(row_m1), .row_0(row_0), .row_p1(row_p1),
        .row_p2(row_p2), .y_frac(y_frac), .dist0(dist0), .dist1(dist1),
        .dist2(dist2), .dist3(dist3)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           chk;
        logic [105:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   fd_cnt = 0;

    function automatic void check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    function automatic void push(input bit chk, input logic [11:0] dr, input logic [11:0] m1,
                                 input logic [11:0] r0, input logic [11:0] p1, input logic [11:0] p2,
                                 input logic [7:0] fr, input logic [9:0] d0, input logic [8:0] d1,
                                 input logic [8:0] d2, input logic [9:0] d3);
        exp_t e;
        e.chk = chk;
        e.v   = {dr, m1, r0, p1, p2, fr, d0, d1, d2, d3};
        q.push_back(e);
    endfunction

    // Monitor: every row_valid pulse consumes one scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && frame_done) fd_cnt++;
        if (rst_n && row_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_row_valid dst_row=%0d", dst_row);
            end else begin
                e = q.pop_front();
                if (e.chk)
                    check("line", {22'd0, dst_row, row_m1, row_0, row_p1, row_p2, y_frac,
                                   dist0, dist1, dist2, dist3}, {22'd0, e.v});
            end
        end
    end

    task automatic start(input logic [11:0] s, input logic [11:0] d, input logic [19:0] st);
        src_height  = s;
        dst_height  = d;
        step        = st;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic req();
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!row_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!row_valid) begin
            total++;
            bad++;
            $display("FAIL row_valid_timeout got=0 exp=1");
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("reset_outs", {row_valid, busy, frame_done, dst_row, row_m1, row_0, row_p1, row_p2,
                             y_frac, dist0, dist1, dist2, dist3}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Upscale 1080 -> 2160, step 128
        push(1, 0, 0, 0, 1, 2, 0, 256, 0, 256, 512);
        start(1080, 2160, 128);
        check("rv_latency_start", row_valid, 0);
        req();                                   // lands in CALC, must be dropped
        check("rv_after_e1", row_valid, 1);
        check("calc_req_drop", dst_row, 0);
        wait_rv();
        push(1, 1, 0, 0, 1, 2, 64, 320, 64, 192, 448);
        req();
        check("rv_latency_req_early", row_valid, 0);
        @(negedge clk);
        check("rv_latency_req", row_valid, 1);
        for (int i = 2; i < 2159; i++) begin
            push(0, 12'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            req();
            wait_rv();
        end
        push(1, 2159, 1078, 1079, 1079, 1079, 0, 256, 0, 256, 512);
        req();
        wait_rv();
        check("busy_last_line", busy, 1);
        req();
        check("frame_done_pulse", frame_done, 1);
        check("busy_fall", busy, 0);
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 0);
        check("hold_row0_idle", row_0, 1079);

        // Downscale 2160 -> 1080, step 512
        push(1, 0, 0, 0, 1, 2, 128, 384, 128, 128, 384);
        start(2160, 1080, 512);
        wait_rv();
        push(1, 1, 1, 2, 3, 4, 128, 384, 128, 128, 384);
        req();
        wait_rv();
        for (int i = 2; i <= 37; i++) begin
            push(0, 12'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            req();
            wait_rv();
        end
        check("dst_row_37", dst_row, 37);
        push(1, 0, 0, 0, 1, 2, 128, 384, 128, 128, 384);
        start(2160, 1080, 512);
        check("restart_dst_row", dst_row, 0);
        wait_rv();
        push(1, 1, 1, 2, 3, 4, 128, 384, 128, 128, 384);
        req();
        wait_rv();

        // Asynchronous reset mid-frame
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {row_valid, busy, frame_done, dst_row, row_m1, row_0, row_p1,
                                   row_p2, y_frac, dist0, dist1, dist2, dist3}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero destination height is ignored
        start(100, 0, 256);
        check("dst0_busy_a", busy, 0);
        @(negedge clk);
        check("dst0_busy_b", busy, 0);

        // Fresh frame after reset
        push(1, 0, 0, 0, 1, 2, 0, 256, 0, 256, 512);
        start(1080, 2160, 128);
        wait_rv();

        // Single source row, restarted from WAIT
        push(1, 0, 0, 0, 0, 0, 0, 256, 0, 256, 512);
        start(1, 4, 64);
        wait_rv();
        push(1, 1, 0, 0, 0, 0, 0, 256, 0, 256, 512);
        req();
        wait_rv();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        check("frame_done_count", fd_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
